// File: rtl/wav_header_writer.sv
// wav_header_writer: serialises a canonical 44-byte PCM WAV header from latched config, then forwards the payload
module wav_header_writer #(
  parameter logic [15:0] AUDIO_FORMAT = 16'd1,
  parameter logic [31:0] FMT_SIZE = 32'd16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] sample_rate,
  input  logic [15:0] num_channels,
  input  logic [15:0] bit_depth,
  input  logic [31:0] data_bytes,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [7:0]  out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_last,
  output logic        busy,
  output logic        cfg_error
);
  typedef enum logic [1:0] {IDLE, CALC, HEADER, PAYLOAD} state_t;
  state_t state, state_nx;
  logic [31:0] sr, db, byte_rate, riff_size, remaining;
  logic [15:0] nc, bd, block_align, ba_calc;
  logic [5:0] idx;
  logic [7:0] hdr_q;
  logic [351:0] hdr;
  logic bad_cfg;
  assign bad_cfg = bit_depth == 16'd0 || bit_depth[2:0] != 3'd0 || num_channels == 16'd0;
  assign ba_calc = nc * (bd >> 3);
  assign busy = state != IDLE;
  assign hdr = {db, 32'h6174_6164, bd, block_align, byte_rate, sr, nc, AUDIO_FORMAT, FMT_SIZE,
                32'h2074_6d66, 32'h4556_4157, riff_size, 32'h4646_4952};
  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  // next state and byte-stream outputs; payload is a combinational passthrough
  always_comb begin
    state_nx = state;
    out_data = hdr_q;
    out_valid = 1'b0;
    in_ready = 1'b0;
    out_last = 1'b0;
    case (state)
      IDLE: state_nx = start && !bad_cfg ? CALC : IDLE;
      CALC: state_nx = HEADER;
      HEADER: begin
        out_valid = 1'b1;
        out_last = idx == 6'd43 && db == 32'd0;
        if (out_ready && idx == 6'd43) state_nx = db == 32'd0 ? IDLE : PAYLOAD;
      end
      PAYLOAD: begin
        out_data = in_data;
        out_valid = in_valid;
        in_ready = out_ready;
        out_last = remaining == 32'd1;
        if (in_valid && out_ready && remaining == 32'd1) state_nx = IDLE;
      end
    endcase
  end
  // config latch, derived fields, header byte register and payload countdown
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sr <= '0;
      nc <= '0;
      bd <= '0;
      db <= '0;
      block_align <= '0;
      byte_rate <= '0;
      riff_size <= '0;
      remaining <= '0;
      idx <= '0;
      hdr_q <= '0;
      cfg_error <= 1'b0;
    end else begin
      if (state == IDLE && start) begin
        sr <= sample_rate;
        nc <= num_channels;
        bd <= bit_depth;
        db <= data_bytes;
        cfg_error <= bad_cfg;
      end
      if (state == CALC) begin
        block_align <= ba_calc;
        byte_rate <= sr * {16'd0, ba_calc};
        riff_size <= db + 32'd36;
        remaining <= db;
        idx <= '0;
        hdr_q <= 8'h52;
      end
      if (state == HEADER && out_ready) begin
        idx <= idx + 6'd1;
        hdr_q <= idx == 6'd43 ? 8'd0 : hdr[{idx + 6'd1, 3'd0} +: 8];
      end
      if (state == PAYLOAD && in_valid && out_ready) remaining <= remaining - 32'd1;
    end
endmodule

// File: tb/tb_wav_header_writer.sv
// tb_wav_header_writer: table-driven file runs checked against hand-computed header fields, plus reset/error sequences
module tb_wav_header_writer;
  logic clk = 1'b0, rst_n = 1'b1, start = 1'b0;
  logic [31:0] sample_rate = '0, data_bytes = '0;
  logic [15:0] num_channels = '0, bit_depth = '0;
  logic [7:0] in_data = '0, out_data;
  logic in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b0, out_last, busy, cfg_error;
  int n_vec = 0, n_bad = 0, cur = 0;

  typedef struct {
    logic [31:0] sr;
    logic [15:0] nc, bd;
    logic [31:0] db;
    bit err;
    logic [15:0] ba;
    logic [31:0] br, riff;
    bit stall, disturb;
  } vec_t;
  vec_t tbl [12];

  wav_header_writer dut (
    .clk(clk), .rst_n(rst_n), .start(start), .sample_rate(sample_rate), .num_channels(num_channels),
    .bit_depth(bit_depth), .data_bytes(data_bytes), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .busy(busy), .cfg_error(cfg_error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL v%0d %s: got %0h expected %0h", cur, name, act, exp);
    end
  endtask

  function automatic logic [7:0] pay(input int k);
    return 8'(k * 37 + 11);
  endfunction

  function automatic logic [7:0] exp_hdr(input vec_t v, input int i);
    logic [7:0] h [44];
    h[0] = 8'h52; h[1] = 8'h49; h[2] = 8'h46; h[3] = 8'h46;
    h[8] = 8'h57; h[9] = 8'h41; h[10] = 8'h56; h[11] = 8'h45;
    h[12] = 8'h66; h[13] = 8'h6D; h[14] = 8'h74; h[15] = 8'h20;
    h[36] = 8'h64; h[37] = 8'h61; h[38] = 8'h74; h[39] = 8'h61;
    for (int b = 0; b < 4; b++) begin
      h[4 + b] = 8'(v.riff >> (8 * b));
      h[16 + b] = b == 0 ? 8'h10 : 8'h00;
      h[24 + b] = 8'(v.sr >> (8 * b));
      h[28 + b] = 8'(v.br >> (8 * b));
      h[40 + b] = 8'(v.db >> (8 * b));
    end
    for (int b = 0; b < 2; b++) begin
      h[20 + b] = b == 0 ? 8'h01 : 8'h00;
      h[22 + b] = 8'(v.nc >> (8 * b));
      h[32 + b] = 8'(v.ba >> (8 * b));
      h[34 + b] = 8'(v.bd >> (8 * b));
    end
    return h[i];
  endfunction

  task automatic pulse_start(input vec_t v);
    @(posedge clk); #1;
    sample_rate = v.sr; num_channels = v.nc; bit_depth = v.bd; data_bytes = v.db;
    in_valid = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic run_file(input vec_t v);
    logic [7:0] got [$];
    logic [7:0] hd = '0;
    int last_at = -1, first_v = -1, k = 0, hdr_ir = 0, seen = 0;
    bit done = 1'b0, hstall = 1'b0;
    pulse_start(v);
    if (v.err) begin
      @(negedge clk);
      chk("cfg_error_set", cfg_error, 1'b1);
      chk("busy_on_error", busy, 1'b0);
      for (int c = 0; c < 4; c++) begin
        @(negedge clk);
        if (out_valid || busy) seen++;
      end
      chk("error_emits_nothing", seen, 0);
      return;
    end
    for (int cyc = 0; cyc < 30000 && !done; cyc++) begin
      out_ready = v.stall ? 1'($urandom_range(0, 1)) : 1'b1;
      in_valid = v.stall ? ($urandom_range(0, 3) != 0) : 1'b1;
      in_data = pay(k);
      if (v.disturb && cyc % 13 == 7) begin
        start = 1'b1;
        sample_rate = $urandom;
        num_channels = 16'($urandom);
        bit_depth = 16'd8;
        data_bytes = $urandom_range(1, 9);
      end else start = 1'b0;
      @(negedge clk);
      if (cyc == 0) chk("cfg_error_cleared", cfg_error, 1'b0);
      if (hstall) begin
        chk("stall_hold_valid", out_valid, 1'b1);
        chk("stall_hold_data", out_data, hd);
      end
      hstall = out_valid && !out_ready && got.size() < 44;
      hd = out_data;
      if (first_v < 0 && out_valid) first_v = cyc;
      if (got.size() < 44 && in_ready) hdr_ir++;
      if (out_valid && out_ready) begin
        got.push_back(out_data);
        if (out_last) begin
          last_at = got.size() - 1;
          done = 1'b1;
        end
      end
      if (in_valid && in_ready) k++;
      @(posedge clk); #1;
    end
    start = 1'b0;
    in_valid = 1'b0;
    chk("file_done", done, 1'b1);
    chk("length", got.size(), 64'(v.db) + 64'd44);
    chk("last_position", last_at, 64'(v.db) + 64'd43);
    chk("payload_taken", k, v.db);
    chk("in_ready_in_header", hdr_ir, 0);
    if (!v.stall) chk("first_byte_latency", first_v, 1);
    for (int i = 0; i < got.size() && i < 44 + int'(v.db); i++)
      chk($sformatf("byte%0d", i), got[i], i < 44 ? exp_hdr(v, i) : pay(i - 44));
    @(negedge clk);
    chk("busy_after", busy, 1'b0);
    chk("in_ready_after", in_ready, 1'b0);
    chk("cfg_error_after", cfg_error, 1'b0);
  endtask

  initial begin
    int n;
    tbl[0]  = '{32'd44100, 16'd2, 16'd16, 32'd8, 1'b0, 16'd4, 32'd176400, 32'd44, 1'b0, 1'b0};
    tbl[1]  = '{32'd48000, 16'd1, 16'd24, 32'd0, 1'b0, 16'd3, 32'd144000, 32'd36, 1'b0, 1'b0};
    tbl[2]  = '{32'd8000, 16'd1, 16'd8, 32'd5, 1'b0, 16'd1, 32'd8000, 32'd41, 1'b0, 1'b0};
    tbl[3]  = '{32'd96000, 16'd6, 16'd32, 32'd3, 1'b0, 16'd24, 32'd2304000, 32'd39, 1'b0, 1'b0};
    tbl[4]  = '{32'h8000_0000, 16'd2, 16'd16, 32'd2, 1'b0, 16'd4, 32'd0, 32'd38, 1'b0, 1'b0};
    tbl[5]  = '{32'd1, 16'hFFFF, 16'd16, 32'd1, 1'b0, 16'hFFFE, 32'h0000_FFFE, 32'd37, 1'b0, 1'b0};
    tbl[6]  = '{32'd44100, 16'd2, 16'd12, 32'd4, 1'b1, 16'd0, 32'd0, 32'd0, 1'b0, 1'b0};
    tbl[7]  = '{32'd44100, 16'd0, 16'd16, 32'd4, 1'b1, 16'd0, 32'd0, 32'd0, 1'b0, 1'b0};
    tbl[8]  = '{32'd22050, 16'd1, 16'd16, 32'd6, 1'b0, 16'd2, 32'd44100, 32'd42, 1'b0, 1'b0};
    tbl[9]  = '{32'd16000, 16'd2, 16'd16, 32'd1000, 1'b0, 16'd4, 32'd64000, 32'd1036, 1'b1, 1'b0};
    tbl[10] = '{32'd11025, 16'd1, 16'd8, 32'd20, 1'b0, 16'd1, 32'd11025, 32'd56, 1'b1, 1'b1};
    tbl[11] = '{32'd8000, 16'd1, 16'd0, 32'd4, 1'b1, 16'd0, 32'd0, 32'd0, 1'b0, 1'b0};
    #2 rst_n = 1'b0;
    #1;
    chk("reset_out_data", out_data, 8'h00);
    chk("reset_out_valid", out_valid, 1'b0);
    chk("reset_out_last", out_last, 1'b0);
    chk("reset_in_ready", in_ready, 1'b0);
    chk("reset_busy", busy, 1'b0);
    chk("reset_cfg_error", cfg_error, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int v = 0; v < 12; v++) begin
      cur = v;
      run_file(tbl[v]);
    end
    cur = 12;
    pulse_start(tbl[0]);
    out_ready = 1'b1;
    n = 0;
    for (int c = 0; c < 100 && n < 20; c++) begin
      @(negedge clk);
      if (out_valid && out_ready) n++;
      @(posedge clk); #1;
    end
    chk("pre_reset_byte20", out_data, 8'h01);
    chk("pre_reset_valid", out_valid, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("mid_reset_valid", out_valid, 1'b0);
    chk("mid_reset_data", out_data, 8'h00);
    chk("mid_reset_busy", busy, 1'b0);
    @(posedge clk); #1 rst_n = 1'b1;
    run_file(tbl[0]);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
